// File: rtl/snake_pixel_renderer_pkg.sv
// Shared constants for the snake renderer: headings, grid geometry, reset
// position, palette and FSM state encodings.
package snake_pixel_renderer_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam int GRID_W     = 40;
    localparam int GRID_H     = 30;
    localparam int CELL_SHIFT = 4;

    localparam int HEAD_X0 = 20;
    localparam int HEAD_Y0 = 15;

    localparam logic [11:0] COL_BG     = 12'h048;
    localparam logic [11:0] COL_BODY   = 12'hFF0;
    localparam logic [11:0] COL_HEAD   = 12'hF80;
    localparam logic [11:0] COL_TARGET = 12'hF00;
    localparam logic [11:0] COL_DEAD   = 12'h888;

    localparam logic ST_PLAY = 1'b0;
    localparam logic ST_DEAD = 1'b1;

    typedef struct packed {
        logic [5:0] x;
        logic [4:0] y;
    } cell_t;

    // Opposite headings differ only in the top bit (up/down, right/left).
    function automatic logic [1:0] reverse_dir(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/snake_pixel_renderer_next_head.sv
// Combinational head step: filters a reversing request, then steps one cell
// with toroidal wrap-around on both axes.
module snake_next_head
    import snake_pixel_renderer_pkg::*;
(
    input  logic [5:0] head_x,
    input  logic [4:0] head_y,
    input  logic [1:0] cur_dir,
    input  logic [1:0] req_dir,
    output logic [1:0] new_dir,
    output logic [5:0] next_x,
    output logic [4:0] next_y
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        new_dir = (req_dir == reverse_dir(cur_dir)) ? cur_dir : req_dir;
        next_x  = head_x;
        next_y  = head_y;
        case (new_dir)
            DIR_UP:    next_y = (head_y == 5'd0) ? 5'(GRID_H - 1) : head_y - 5'd1;
            DIR_RIGHT: next_x = (head_x == 6'(GRID_W - 1)) ? 6'd0 : head_x + 6'd1;
            DIR_DOWN:  next_y = (head_y == 5'(GRID_H - 1)) ? 5'd0 : head_y + 5'd1;
            default:   next_x = (head_x == 6'd0) ? 6'(GRID_W - 1) : head_x - 6'd1;
        endcase
    end

endmodule

// File: rtl/snake_pixel_renderer.sv
// Snake game core: segment shift register, growth/collision detection and a
// registered pixel-to-colour lookup feeding the VGA interface.
module snake_pixel_renderer
    import snake_pixel_renderer_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MOVE_TICK,
    input  logic [1:0]  DIRECTION,
    input  logic [5:0]  TARGET_X,
    input  logic [4:0]  TARGET_Y,
    input  logic [9:0]  ADDRH,
    input  logic [8:0]  ADDRV,
    output logic [11:0] COLOUR,
    output logic        TARGET_REACHED,
    output logic [5:0]  SNAKE_LENGTH,
    output logic        FAILED
);

    cell_t       seg [MAX_LEN];
    logic        state;
    logic [1:0]  heading;
    logic [1:0]  new_dir;
    cell_t       next_cell;
    cell_t       target_cell;
    cell_t       pix_cell;

    logic        move;
    logic        grow;
    logic        collide;
    logic        do_shift;
    logic [5:0]  coll_lim;
    logic [MAX_LEN-1:0] coll_hit;
    logic [MAX_LEN-1:0] body_hit;

    logic        in_grid;
    logic        head_hit;
    logic        target_hit;
    logic [11:0] colour_d;

    snake_next_head u_next_head (
        .head_x  (seg[0].x),
        .head_y  (seg[0].y),
        .cur_dir (heading),
        .req_dir (DIRECTION),
        .new_dir (new_dir),
        .next_x  (next_cell.x),
        .next_y  (next_cell.y)
    );

    assign target_cell = '{x: TARGET_X, y: TARGET_Y};
    assign move        = MOVE_TICK && (state == ST_PLAY);
    assign grow        = (next_cell == target_cell);
    // The tail cell is free on a plain move because it shifts away this tick.
    assign coll_lim    = grow ? SNAKE_LENGTH : SNAKE_LENGTH - 6'd1;

    assign pix_cell.x  = 6'(ADDRH >> CELL_SHIFT);
    assign pix_cell.y  = 5'(ADDRV >> CELL_SHIFT);
    assign in_grid     = (ADDRH < 10'(GRID_W << CELL_SHIFT)) && (ADDRV < 9'(GRID_H << CELL_SHIFT));

    for (genvar i = 0; i < MAX_LEN; i++) begin : g_match
        assign coll_hit[i] = (seg[i] == next_cell) && (6'(i) < coll_lim);
        assign body_hit[i] = (i >= 1) && (seg[i] == pix_cell) && (6'(i) < SNAKE_LENGTH);
    end

    assign collide    = |coll_hit;
    assign do_shift   = move && !collide;
    assign head_hit   = (seg[0] == pix_cell);
    assign target_hit = (target_cell == pix_cell);

    always_comb begin
        colour_d = COL_BG;
        if (in_grid) begin
            if (head_hit)
                colour_d = (state == ST_DEAD) ? COL_DEAD : COL_HEAD;
            else if (|body_hit)
                colour_d = (state == ST_DEAD) ? COL_DEAD : COL_BODY;
            else if (target_hit)
                colour_d = COL_TARGET;
        end
    end

    // NOTE: only the INIT_LEN live segments take a reset value; higher entries are never read until shifted into.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < INIT_LEN) begin
                    seg[i].x <= 6'(HEAD_X0 - i);
                    seg[i].y <= 5'(HEAD_Y0);
                end
            end
        end else if (do_shift) begin
            seg[0] <= next_cell;
            for (int i = 1; i < MAX_LEN; i++)
                seg[i] <= seg[i-1];
        end
    end

    // NOTE: non-blocking assignments keep every register reading pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= ST_PLAY;
            heading        <= DIR_RIGHT;
            SNAKE_LENGTH   <= 6'(INIT_LEN);
            TARGET_REACHED <= 1'b0;
            COLOUR         <= 12'h000;
        end else begin
            TARGET_REACHED <= 1'b0;
            COLOUR         <= colour_d;
            if (move) begin
                heading <= new_dir;
                if (collide) begin
                    state <= ST_DEAD;
                end else if (grow) begin
                    TARGET_REACHED <= 1'b1;
                    if (SNAKE_LENGTH < 6'(MAX_LEN))
                        SNAKE_LENGTH <= SNAKE_LENGTH + 6'd1;
                end
            end
        end
    end

    assign FAILED = (state == ST_DEAD);

endmodule

// File: tb/tb_snake_pixel_renderer.sv
// Directed bench: a pixel-vector table for the reset picture, then hand-written
// sequences for wrap, reverse filtering, growth, collision and saturation.
module tb_snake_pixel_renderer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MOVE_TICK;
    logic [1:0]  DIRECTION;
    logic [5:0]  TARGET_X;
    logic [4:0]  TARGET_Y;
    logic [9:0]  ADDRH;
    logic [8:0]  ADDRV;

    logic [11:0] colour,   colour_s;
    logic        reached,  reached_s;
    logic [5:0]  length,   length_s;
    logic        failed,   failed_s;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    snake_pixel_renderer dut (
        .CLK(CLK), .RESET(RESET), .MOVE_TICK(MOVE_TICK), .DIRECTION(DIRECTION),
        .TARGET_X(TARGET_X), .TARGET_Y(TARGET_Y), .ADDRH(ADDRH), .ADDRV(ADDRV),
        .COLOUR(colour), .TARGET_REACHED(reached), .SNAKE_LENGTH(length), .FAILED(failed)
    );

    snake_pixel_renderer #(.MAX_LEN(5), .INIT_LEN(4)) dut_sat (
        .CLK(CLK), .RESET(RESET), .MOVE_TICK(MOVE_TICK), .DIRECTION(DIRECTION),
        .TARGET_X(TARGET_X), .TARGET_Y(TARGET_Y), .ADDRH(ADDRH), .ADDRV(ADDRV),
        .COLOUR(colour_s), .TARGET_REACHED(reached_s), .SNAKE_LENGTH(length_s), .FAILED(failed_s)
    );

    typedef struct {
        logic [9:0]  h;
        logic [8:0]  v;
        logic [11:0] col;
        string       name;
    } pix_vec_t;

    pix_vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] px(input int cx);
        return 10'(cx * 16 + 8);
    endfunction

    function automatic logic [8:0] py(input int cy);
        return 9'(cy * 16 + 8);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        MOVE_TICK = 1'b0;
        repeat (3) step();
        RESET = 1'b0;
    endtask

    // One pulse, then idle so the tick spacing is 8 cycles.
    task automatic move(input logic [1:0] dir);
        DIRECTION = dir;
        MOVE_TICK = 1'b1;
        step();
        MOVE_TICK = 1'b0;
        repeat (7) step();
    endtask

    task automatic pix(input string name, input int cx, input int cy, input logic [11:0] exp);
        ADDRH = px(cx);
        ADDRV = py(cy);
        step();
        check(name, colour, exp);
    endtask

    task automatic pix_s(input string name, input int cx, input int cy, input logic [11:0] exp);
        ADDRH = px(cx);
        ADDRV = py(cy);
        step();
        check(name, colour_s, exp);
    endtask

    initial begin
        vecs[0] = '{10'd325, 9'd245, 12'hF80, "rst_head"};
        vecs[1] = '{10'd310, 9'd245, 12'hFF0, "rst_body1"};
        vecs[2] = '{10'd290, 9'd245, 12'hFF0, "rst_body2"};
        vecs[3] = '{10'd280, 9'd245, 12'hFF0, "rst_tail"};
        vecs[4] = '{10'd270, 9'd245, 12'h048, "rst_past_tail"};
        vecs[5] = '{10'd600, 9'd20,  12'h048, "rst_bg"};
        vecs[6] = '{10'd88,  9'd88,  12'hF00, "rst_target"};
        vecs[7] = '{10'd640, 9'd245, 12'h048, "rst_h_offgrid"};
        vecs[8] = '{10'd325, 9'd480, 12'h048, "rst_v_offgrid"};

        RESET = 1'b1;
        MOVE_TICK = 1'b0;
        DIRECTION = 2'b01;
        TARGET_X = 6'd5;
        TARGET_Y = 5'd5;
        ADDRH = 10'd325;
        ADDRV = 9'd245;
        repeat (3) step();
        check("reset_colour", colour, 12'h000);
        check("reset_reached", reached, 1'b0);
        check("reset_failed", failed, 1'b0);
        check("reset_length", length, 6'd4);
        RESET = 1'b0;

        // Scenario 1: reset picture.
        for (int i = 0; i < 9; i++) begin
            ADDRH = vecs[i].h;
            ADDRV = vecs[i].v;
            step();
            check(vecs[i].name, colour, vecs[i].col);
        end

        // Scenario 2: straight run right with wrap at x=39.
        for (int k = 1; k <= 20; k++) begin
            move(2'b01);
            pix($sformatf("run_head_%0d", k), (20 + k) % 40, 15, 12'hF80);
        end
        pix("wrap_body", 39, 15, 12'hFF0);
        check("run_failed", failed, 1'b0);
        check("run_length", length, 6'd4);

        // Scenario 3: reverse request ignored, then turn up.
        do_reset();
        move(2'b11);
        pix("rev_head", 21, 15, 12'hF80);
        pix("rev_old_head", 20, 15, 12'hFF0);
        move(2'b00);
        pix("up_head", 21, 14, 12'hF80);
        pix("up_body", 21, 15, 12'hFF0);

        // Scenario 4: capture the target.
        do_reset();
        TARGET_X = 6'd21;
        TARGET_Y = 5'd15;
        DIRECTION = 2'b01;
        MOVE_TICK = 1'b1;
        step();
        MOVE_TICK = 1'b0;
        check("grow_pulse", reached, 1'b1);
        check("grow_length", length, 6'd5);
        step();
        check("grow_pulse_end", reached, 1'b0);
        pix("grow_tail", 17, 15, 12'hFF0);
        pix("grow_head_over_target", 21, 15, 12'hF80);

        // Scenario 5: up, left, down bites the body at (20,15).
        move(2'b00);
        move(2'b11);
        check("pre_bite_failed", failed, 1'b0);
        move(2'b10);
        check("bite_failed", failed, 1'b1);
        check("bite_length", length, 6'd5);
        pix("dead_head", 20, 14, 12'h888);
        pix("dead_body", 21, 14, 12'h888);
        pix("dead_tail", 19, 15, 12'h888);
        pix("dead_free", 20, 16, 12'h048);
        move(2'b10);
        move(2'b01);
        pix("frozen_head", 20, 14, 12'h888);
        pix("frozen_seg3", 20, 15, 12'h888);
        pix("frozen_no_move", 20, 13, 12'h048);
        check("frozen_length", length, 6'd5);
        do_reset();
        check("rearm_failed", failed, 1'b0);
        check("rearm_length", length, 6'd4);
        pix("rearm_head", 20, 15, 12'hF80);
        pix("rearm_tail", 17, 15, 12'hFF0);
        pix("rearm_stale", 21, 14, 12'h048);
        pix("rearm_target", 21, 15, 12'hF00);

        // Scenario 6: saturation on the MAX_LEN=5 instance.
        move(2'b01);
        check("sat_len5", length_s, 6'd5);
        TARGET_X = 6'd22;
        DIRECTION = 2'b01;
        MOVE_TICK = 1'b1;
        step();
        MOVE_TICK = 1'b0;
        check("sat_pulse", reached_s, 1'b1);
        check("sat_length", length_s, 6'd5);
        check("unsat_length", length, 6'd6);
        step();
        check("sat_pulse_end", reached_s, 1'b0);
        pix_s("sat_tail", 18, 15, 12'hFF0);
        pix_s("sat_dropped", 17, 15, 12'h048);
        pix("unsat_tail", 17, 15, 12'hFF0);

        RESET = 1'b1;
        MOVE_TICK = 1'b1;
        DIRECTION = 2'b01;
        step();
        RESET = 1'b0;
        MOVE_TICK = 1'b0;
        check("rst_tick_length", length_s, 6'd4);
        check("rst_tick_reached", reached_s, 1'b0);
        pix_s("rst_tick_head", 20, 15, 12'hF80);
        pix_s("rst_tick_no_move", 21, 15, 12'h048);
        pix_s("rst_tick_tail", 17, 15, 12'hFF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
